// File: rtl/fb_porta_arbiter.sv
// Port-A owner for the 1-bit 640x480 frame buffer: full-screen clear sweep plus R0/R1 arbitration.
// Define FB_FIXED_PRIO_EN for strict R0-over-R1 priority; the default is round-robin.
module fb_porta_arbiter #(
  parameter int   H_ACTIVE   = 640,
  parameter int   V_ACTIVE   = 480,
  parameter int   MEM_RD_LAT = 2,
  parameter logic CLEAR_VAL  = 1'b0
) (
  input  logic        VGA_CTRL_CLK,
  input  logic        reset,
  input  logic        clear_start,
  output logic        clear_busy,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [9:0]  r0_x,
  input  logic [8:0]  r0_y,
  input  logic        r0_wdata,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic        r0_rdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [9:0]  r1_x,
  input  logic [8:0]  r1_y,
  input  logic        r1_wdata,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic        r1_rdata,
  output logic [18:0] mem_addr,
  output logic        mem_data,
  output logic        mem_we,
  input  logic        mem_q
);

  localparam logic [9:0] X_LIM  = 10'(H_ACTIVE);
  localparam logic [8:0] Y_LIM  = 9'(V_ACTIVE);
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);

  typedef enum logic {CLEAR, ARB} state_t;
  typedef struct packed {
    logic vld;
    logic sel;
    logic oob;
  } rd_tag_t;

  state_t     state;
  logic [9:0] cx;
  logic [8:0] cy;
  rd_tag_t    rd_pipe [MEM_RD_LAT];
  rd_tag_t    rd_out;

  logic       arb_en;
  logic       any_gnt;
  logic       win_sel;
  logic       win_we;
  logic       win_wdata;
  logic [9:0] win_x;
  logic [8:0] win_y;
  logic       in_range;

  assign arb_en = (state == ARB) & ~clear_start & ~reset;

`ifdef FB_FIXED_PRIO_EN
  always_comb begin
    r0_gnt = arb_en & r0_req;
    r1_gnt = arb_en & r1_req & ~r0_req;
  end
`else
  // last = 1 means R1 won most recently, so R0 wins the next contested cycle.
  logic last;
  always_comb begin
    r0_gnt = arb_en & r0_req & (~r1_req | last);
    r1_gnt = arb_en & r1_req & (~r0_req | ~last);
  end
`endif

  assign any_gnt   = r0_gnt | r1_gnt;
  assign win_sel   = r1_gnt;
  assign win_we    = win_sel ? r1_we    : r0_we;
  assign win_wdata = win_sel ? r1_wdata : r0_wdata;
  assign win_x     = win_sel ? r1_x     : r0_x;
  assign win_y     = win_sel ? r1_y     : r0_y;
  assign in_range  = (win_x < X_LIM) && (win_y < Y_LIM);
  assign rd_out    = rd_pipe[MEM_RD_LAT-1];

  always_ff @(posedge VGA_CTRL_CLK) begin
    if (reset) begin
      state      <= CLEAR;
      cx         <= '0;
      cy         <= '0;
      clear_busy <= 1'b1;
      mem_addr   <= '0;
      mem_data   <= 1'b0;
      mem_we     <= 1'b0;
      r0_rvalid  <= 1'b0;
      r0_rdata   <= 1'b0;
      r1_rvalid  <= 1'b0;
      r1_rdata   <= 1'b0;
`ifndef FB_FIXED_PRIO_EN
      last       <= 1'b1;
`endif
      for (int unsigned i = 0; i < MEM_RD_LAT; i++) rd_pipe[i] <= '0;
    end else begin
      // The read pipeline keeps running in CLEAR so reads issued before a clear still return.
      rd_pipe[0] <= {any_gnt & ~win_we, win_sel, ~in_range};
      for (int unsigned i = 1; i < MEM_RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];

      r0_rvalid <= rd_out.vld & ~rd_out.sel;
      r1_rvalid <= rd_out.vld & rd_out.sel;
      if (rd_out.vld & ~rd_out.sel) r0_rdata <= ~rd_out.oob & mem_q;
      if (rd_out.vld & rd_out.sel)  r1_rdata <= ~rd_out.oob & mem_q;

      case (state)
        CLEAR: begin
          mem_addr <= {cx, cy};
          mem_data <= CLEAR_VAL;
          mem_we   <= 1'b1;
          if (cx == X_LAST) begin
            cx <= '0;
            if (cy == Y_LAST) begin
              cy         <= '0;
              state      <= ARB;
              clear_busy <= 1'b0;
            end else begin
              cy <= cy + 9'd1;
            end
          end else begin
            cx <= cx + 10'd1;
          end
        end
        ARB: begin
          if (clear_start) begin
            state      <= CLEAR;
            clear_busy <= 1'b1;
            cx         <= '0;
            cy         <= '0;
            mem_we     <= 1'b0;
          end else if (any_gnt) begin
            mem_addr <= {win_x, win_y};
            mem_data <= win_wdata;
            mem_we   <= win_we & in_range;
`ifndef FB_FIXED_PRIO_EN
            last     <= win_sel;
`endif
          end else begin
            mem_we <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
